// File: rtl/sysref_pkg.sv
// Shared types, default widths and the period tolerance compare for the SYSREF sync controller.
package sysref_pkg;

    localparam int DEF_PERIOD_W     = 16;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_SETTLE_EDGES = 4;
    localparam int DEF_TOL          = 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE,
        RELEASE,
        DONE,
        ERROR
    } state_e;

    // True when |period - expected| <= tol; operands zero-extended to 32 bits by the caller.
    function automatic logic period_match(input logic [31:0] period,
                                          input logic [31:0] expected,
                                          input logic [31:0] tol);
        logic [31:0] diff;
        diff = (period >= expected) ? (period - expected) : (expected - period);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/sysref_sync_ctrl_edge_timer.sv
// SYSREF rise detector with saturating period counter and last-measured-period register.
module sysref_edge_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                pl_clock,
    input  logic                pl_resetn,
    input  logic                sysref_in,
    output logic                rise,
    output logic [PERIOD_W-1:0] period_cnt,
    output logic [PERIOD_W-1:0] period_meas,
    output logic                cnt_sat
);

    logic                sysref_d_q, sysref_d_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] meas_q, meas_d;

    always_comb begin
        rise       = sysref_in & ~sysref_d_q;
        cnt_sat    = &cnt_q;
        sysref_d_d = sysref_in;
        meas_d     = meas_q;
        if (rise) begin
            cnt_d  = PERIOD_W'(1);
            meas_d = cnt_q;
        end else if (cnt_sat) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge pl_clock) begin
        if (!pl_resetn) begin
            sysref_d_q <= 1'b0;
            cnt_q      <= '0;
            meas_q     <= '0;
        end else begin
            sysref_d_q <= sysref_d_d;
            cnt_q      <= cnt_d;
            meas_q     <= meas_d;
        end
    end

    assign period_cnt  = cnt_q;
    assign period_meas = meas_q;

endmodule

// File: rtl/sysref_sync_ctrl.sv
// SYSREF period-lock sequencer and whole-pulse forwarding gate (pl_clock domain).
// Optional macro SYSREF_SYNC_TIMEOUT_EN: period counter saturation while busy raises ERROR.
module sysref_sync_ctrl
    import sysref_pkg::*;
#(
    parameter int PERIOD_W     = DEF_PERIOD_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int SETTLE_EDGES = DEF_SETTLE_EDGES,
    parameter int TOL          = DEF_TOL
) (
    input  logic                pl_clock,
    input  logic                pl_resetn,
    input  logic                sysref_in,
    input  logic                arm,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [CNT_W-1:0]    cfg_release_edges,
    output logic                sysref_out,
    output logic                busy,
    output logic                locked,
    output logic                err,
    output logic [PERIOD_W-1:0] period_meas,
    output logic [CNT_W-1:0]    edge_count
);

`ifdef SYSREF_SYNC_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic                rise;
    logic                cnt_sat;
    logic [PERIOD_W-1:0] period_cnt;

    sysref_edge_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_edge_timer (
        .pl_clock    (pl_clock),
        .pl_resetn   (pl_resetn),
        .sysref_in   (sysref_in),
        .rise        (rise),
        .period_cnt  (period_cnt),
        .period_meas (period_meas),
        .cnt_sat     (cnt_sat)
    );

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cfg_period_q, cfg_period_d;
    logic [CNT_W-1:0]    cfg_rel_q, cfg_rel_d;
    logic [CNT_W-1:0]    good_q, good_d;
    logic [CNT_W-1:0]    edge_q, edge_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic                match;
    logic                timeout;
    logic                start;
    logic                arm_ok;
    logic [CNT_W-1:0]    good_inc;
    logic [CNT_W-1:0]    edge_inc;

    always_comb begin
        match    = period_match(32'(period_cnt), 32'(cfg_period_q), 32'(TOL));
        timeout  = TIMEOUT_EN & cnt_sat;
        arm_ok   = arm & ~abort;
        good_inc = good_q + CNT_W'(1);
        edge_inc = (&edge_q) ? edge_q : edge_q + CNT_W'(1);

        state_d      = state_q;
        cfg_period_d = cfg_period_q;
        cfg_rel_d    = cfg_rel_q;
        good_d       = good_q;
        edge_d       = edge_q;
        start        = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (arm_ok) begin
                    state_d      = WAIT_FIRST;
                    cfg_period_d = cfg_period;
                    cfg_rel_d    = cfg_release_edges;
                    edge_d       = '0;
                end
            end
            WAIT_FIRST: begin
                if (timeout) begin
                    state_d = ERROR;
                end else if (rise) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    state_d = ERROR;
                end else if (rise) begin
                    if (!match) begin
                        state_d = ERROR;
                    end else begin
                        good_d = good_inc;
                        if (good_inc == CNT_W'(SETTLE_EDGES)) begin
                            state_d = RELEASE;
                        end
                    end
                end
            end
            RELEASE: begin
                if (timeout) begin
                    state_d = ERROR;
                end else if (rise) begin
                    if (!match) begin
                        state_d = ERROR;
                    end else if (!abort && ((cfg_rel_q == '0) || (edge_q < cfg_rel_q))) begin
                        start  = 1'b1;
                        edge_d = edge_inc;
                        if ((cfg_rel_q != '0) && (edge_inc == cfg_rel_q)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
        end

        // The gate holds itself open until sysref_in falls, independent of state, so pulses are never cut.
        out_d    = sysref_in & (out_q | start);
        busy_d   = (state_d == WAIT_FIRST) || (state_d == MEASURE) || (state_d == RELEASE);
        locked_d = (state_d == RELEASE) || (state_d == DONE);
        err_d    = (state_d == ERROR);
    end

    always_ff @(posedge pl_clock) begin
        if (!pl_resetn) begin
            state_q      <= IDLE;
            cfg_period_q <= '0;
            cfg_rel_q    <= '0;
            good_q       <= '0;
            edge_q       <= '0;
            out_q        <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_period_q <= cfg_period_d;
            cfg_rel_q    <= cfg_rel_d;
            good_q       <= good_d;
            edge_q       <= edge_d;
            out_q        <= out_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    assign sysref_out = out_q;
    assign busy       = busy_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign edge_count = edge_q;

endmodule

// File: doc/sysref_sync_ctrl.md
# sysref_sync_ctrl

Sequencing controller for the PL SYSREF path in the `pl_clock` domain. It takes the registered SYSREF sample produced by the PL capture flop and checks that the SYSREF period is stable against a programmed value. Once stable, it opens a gate that forwards a programmed number of whole SYSREF pulses (or a continuous stream) to the RF-ADC/RF-DAC sync logic. It then reports lock or error to software.

## Interface
- `PERIOD_W`, 16: width of the period counter and period config.
- `CNT_W`, 8: width of the edge counters.
- `SETTLE_EDGES`, 4: consecutive in-tolerance periods required before release.
- `TOL`, 1: allowed period deviation in cycles (±).
- `pl_clock`  in  1  sole clock.
- `pl_resetn`  in  1  reset, synchronous, active-low.
- `sysref_in`  in  1  SYSREF already registered in the `pl_clock` domain.
- `arm`  in  1  single-cycle start request.
- `abort`  in  1  single-cycle stop request.
- `cfg_period`  in  PERIOD_W  expected SYSREF period in `pl_clock` cycles; sampled on accepted `arm`.
- `cfg_release_edges`  in  CNT_W  number of pulses to forward (0 = continuous); sampled on accepted `arm`.
- `sysref_out`  out  1  gated, registered SYSREF to the converters.
- `busy`  out  1  high in WAIT_FIRST, MEASURE, RELEASE.
- `locked`  out  1  high in RELEASE and DONE.
- `err`  out  1  high in ERROR.
- `period_meas`  out  PERIOD_W  last measured period.
- `edge_count`  out  CNT_W  pulses forwarded since the last accepted `arm`.

## Operation
- Rise detection: `rise = sysref_in & ~sysref_d`, where `sysref_d` is a 1-cycle delayed copy of `sysref_in`.
- Period counter:
  - Cleared to 1 on a rise; otherwise increments, saturating at all-ones.
  - On each rise, `period_meas` takes the counter value. Example: rises at cycles 10 and 42 give 32.
- A period matches when `|period − cfg_period| ≤ TOL`.
- States (one-hot or binary, from the package):
  - IDLE: accepted `arm` → WAIT_FIRST; cfg registers loaded; `edge_count` cleared.
  - WAIT_FIRST: first rise → MEASURE with the good count cleared. The first rise is never measured.
  - MEASURE:
    - A rise with a match increments the good count. Reaching SETTLE_EDGES → RELEASE.
    - A rise without a match → ERROR.
  - RELEASE:
    - Each rise while `edge_count < cfg_release_edges` (or `cfg_release_edges == 0`) starts a forwarded pulse and increments `edge_count`.
    - When `edge_count` reaches a nonzero `cfg_release_edges` → DONE.
    - A mismatched period in RELEASE → ERROR.
  - DONE: gate closed, `locked` held. `arm` → WAIT_FIRST (re-run).
  - ERROR: sticky. `arm` → WAIT_FIRST; `abort` → IDLE.
- `arm` is ignored in WAIT_FIRST, MEASURE and RELEASE.
- `abort` from any state → IDLE next cycle. `abort` wins over a simultaneous `arm`.
- Forwarding: a pulse is forwarded whole. It starts on its qualifying rise and ends when `sysref_in` falls, even if the state leaves RELEASE meanwhile. No partial pulse is ever emitted.
- `edge_count` saturates at all-ones in continuous mode.

## Timing
- Reset (`pl_resetn` low at a `pl_clock` edge): state IDLE; all outputs 0; counters 0.
- `sysref_out` = `sysref_in` delayed 1 cycle when forwarding. Output pulse width equals input pulse width.
- State transitions take effect on the cycle after the triggering rise or request.
- Flags (`busy`, `locked`, `err`) are registered decodes of state, so they are valid the cycle the new state is entered.
- The release decision is made on the same rise that completes SETTLE_EDGES. The first forwarded pulse is the next rise.
- `cfg_*` changes after arm have no effect until the next accepted `arm`.

## Configuration
- `SYSREF_SYNC_TIMEOUT_EN` defined: period counter saturation in WAIT_FIRST, MEASURE or RELEASE → ERROR (missing SYSREF detected).
- Not defined: saturation holds the counter at all-ones and the controller waits indefinitely. The next rise then compares against the saturated value.

## Structure
- Package `sysref_pkg`:
  - state enum: IDLE, WAIT_FIRST, MEASURE, RELEASE, DONE, ERROR;
  - default widths;
  - the tolerance-compare function.
- Sub-module `sysref_edge_timer`: edge detect, saturating period counter, `period_meas` register, saturation flag. The FSM and gate live in the top.

## Test plan
- Reset: assert `pl_resetn`=0 mid-RELEASE → next cycle state IDLE; `sysref_out`, `busy`, `locked`, `err`, `period_meas`, `edge_count` all 0.
- Nominal finite release:
  - Stimulus: `cfg_period`=32, `cfg_release_edges`=3, SYSREF period 32, width 2.
  - Response: rise 1 is first; rises 2–5 match → RELEASE; rises 6, 7, 8 are forwarded, each 2 wide and 1 cycle late; DONE with `locked`=1, `edge_count`=3; rise 9 is not forwarded.
- Tolerance:
  - A period of 33 (TOL=1) keeps MEASURE.
  - A period of 35 → ERROR, `err`=1, `period_meas`=35.
  - `arm` then restarts to WAIT_FIRST.
- Timeout:
  - With `SYSREF_SYNC_TIMEOUT_EN` and PERIOD_W=8, stopping SYSREF after lock-in gives ERROR 255 cycles after the last rise.
  - Without the macro, the state stays put.
- Abort mid-pulse: `abort` during a forwarded 4-wide pulse → IDLE next cycle, the pulse completes all 4 cycles, and no further pulses are forwarded.
- Simultaneous and continuous:
  - `arm` and `abort` in the same cycle in IDLE → remains IDLE.
  - `cfg_release_edges`=0 forwards every pulse indefinitely with `locked`=1.
